// File: rtl/bfp16_result_pack.sv
// BFP16 adder output stage: packs normal/special results into a 16-bit word,
// buffers them in a 2-entry skid buffer and counts delivered NaN/Inf results.
module bfp16_result_pack #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [7:0]       i_exp,
  input  logic [7:0]       i_man,
  input  logic             i_sel_exp,
  input  logic [1:0]       i_sel_man,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_result,
  output logic             o_flag_nan,
  output logic             o_flag_inf,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_nan,
  output logic [CNT_W-1:0] o_cnt_inf
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  typedef struct packed {
    logic [15:0] result;
    logic        nan;
    logic        inf;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  entry_t     packed_beat;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic [CNT_W-1:0] cnt_nan_q, cnt_nan_d;
  logic [CNT_W-1:0] cnt_inf_q, cnt_inf_d;
  logic       accept, drain;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    packed_beat = '{result: {i_sign, i_exp, i_man[6:0]}, nan: 1'b0, inf: 1'b0};
    if (i_sel_man == 2'b11) begin
      packed_beat = '{result: {~i_sel_exp, 8'hFF, 7'h40}, nan: 1'b1, inf: 1'b0};
    end else if (i_sel_man == 2'b10) begin
      packed_beat = '{result: {~i_sel_exp, 8'hFF, 7'h00}, nan: 1'b0, inf: 1'b1};
    end else if (i_exp == 8'hFF) begin
      packed_beat = '{result: {i_sign, 8'hFF, 7'h00}, nan: 1'b0, inf: 1'b1};
    end else if (!i_man[7]) begin
      // Flush-to-zero: an unnormalised mantissa becomes a signed zero.
      packed_beat = '{result: {i_sign, 15'h0}, nan: 1'b0, inf: 1'b0};
    end
  end

  assign accept = i_valid & ready_q;
  assign drain  = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_d   = packed_beat;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          out_d = packed_beat;
        end else if (accept) begin
          skid_d  = packed_beat;
          state_d = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_FULL);
  end

  // Counters look at the beat leaving the output register, never the incoming one.
  always_comb begin
    cnt_nan_d = cnt_nan_q;
    cnt_inf_d = cnt_inf_q;
    if (i_clr_cnt) begin
      cnt_nan_d = '0;
      cnt_inf_d = '0;
    end else if (drain) begin
      if (out_q.nan && (cnt_nan_q != '1)) cnt_nan_d = cnt_nan_q + 1'b1;
      if (out_q.inf && (cnt_inf_q != '1)) cnt_inf_d = cnt_inf_q + 1'b1;
    end
  end

  // NOTE: the skid entry is reset too; it is only 18 bits and keeps every flop defined.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      cnt_nan_q <= '0;
      cnt_inf_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      cnt_nan_q <= cnt_nan_d;
      cnt_inf_q <= cnt_inf_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_ready    = ready_q;
  assign o_result   = out_q.result;
  assign o_flag_nan = out_q.nan;
  assign o_flag_inf = out_q.inf;
  assign o_cnt_nan  = cnt_nan_q;
  assign o_cnt_inf  = cnt_inf_q;

endmodule

// File: tb/tb_bfp16_result_pack.sv
// Scoreboard bench for bfp16_result_pack: directed beats are queued on accept
// and a negedge monitor checks every drain, handshake state and counter.
module tb_bfp16_result_pack;

  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_sign = 1'b0;
  logic [7:0]    i_exp = '0;
  logic [7:0]    i_man = '0;
  logic          i_sel_exp = 1'b0;
  logic [1:0]    i_sel_man = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [15:0]   o_result;
  logic          o_flag_nan;
  logic          o_flag_inf;
  logic          i_clr_cnt = 1'b0;
  logic [CW-1:0] o_cnt_nan;
  logic [CW-1:0] o_cnt_inf;

  bfp16_result_pack #(.CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_sel_exp(i_sel_exp),
    .i_sel_man(i_sel_man), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_flag_nan(o_flag_nan), .o_flag_inf(o_flag_inf),
    .i_clr_cnt(i_clr_cnt), .o_cnt_nan(o_cnt_nan), .o_cnt_inf(o_cnt_inf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] r;
    logic        nan;
    logic        inf;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            occ = 0;
  logic [CW-1:0] m_nan = '0;
  logic [CW-1:0] m_inf = '0;
  bit            have_stall = 0;
  exp_t          stall_val;
  bit            sent_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Drives one beat and holds it until the DUT accepts it.
  task automatic send(input logic s, input logic [7:0] e, input logic [7:0] m,
                      input logic se, input logic [1:0] sm,
                      input logic [15:0] r, input logic fn, input logic fi);
    exp_t x;
    bit   done;
    done = 0;
    x = {r, fn, fi};
    i_sign = s; i_exp = e; i_man = m; i_sel_exp = se; i_sel_man = sm;
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        sb.push_back(x);
        done = 1;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    if (!done) fail_timeout("accept_timeout");
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while ((sb.size() != 0 || occ != 0) && k < 100) begin
      @(posedge i_clk); #1;
      k++;
    end
    if (k >= 100) fail_timeout("drain_timeout");
  endtask

  // Monitor: checks handshake state against an occupancy model, pops on drains,
  // tracks saturating counters and output stability while stalled.
  always @(negedge i_clk) begin
    exp_t e;
    bit   acc, drn;
    if (i_rst) begin
      sb.delete();
      occ = 0;
      m_nan = '0;
      m_inf = '0;
      have_stall = 0;
    end else begin
      check("o_valid", {31'b0, o_valid}, {31'b0, occ != 0});
      check("o_ready", {31'b0, o_ready}, {31'b0, occ != 2});
      check("cnt_nan", {30'b0, o_cnt_nan}, {30'b0, m_nan});
      check("cnt_inf", {30'b0, o_cnt_inf}, {30'b0, m_inf});
      if (have_stall)
        check("stall_hold", {14'b0, o_result, o_flag_nan, o_flag_inf}, {14'b0, stall_val});
      acc = i_valid && (occ != 2);
      drn = (occ != 0) && i_ready;
      e = '0;
      if (drn) begin
        if (sb.size() == 0) begin
          fail_timeout("unexpected_beat");
        end else begin
          e = sb.pop_front();
          check("result", {14'b0, o_result, o_flag_nan, o_flag_inf}, {14'b0, e});
        end
      end
      if (i_clr_cnt) begin
        m_nan = '0;
        m_inf = '0;
      end else begin
        if (drn && e.nan && m_nan != {CW{1'b1}}) m_nan = m_nan + 1'b1;
        if (drn && e.inf && m_inf != {CW{1'b1}}) m_inf = m_inf + 1'b1;
      end
      occ = occ + int'(acc) - int'(drn);
      have_stall = (occ_before_nonzero(occ, acc, drn)) && !i_ready;
      stall_val = {o_result, o_flag_nan, o_flag_inf};
    end
  end

  // True when the output register held a beat at this sample (occupancy before update).
  function automatic bit occ_before_nonzero(input int o, input bit a, input bit d);
    return (o - int'(a) + int'(d)) != 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_result", {16'b0, o_result}, 32'h0);
    check("rst_flags", {30'b0, o_flag_nan, o_flag_inf}, 32'd0);
    check("rst_cnts", {28'b0, o_cnt_nan, o_cnt_inf}, 32'd0);

    // Normal beat, visible the cycle after acceptance.
    send(1'b0, 8'h80, 8'hC0, 1'b0, 2'b00, 16'h4040, 1'b0, 1'b0);
    check("lat_valid", {31'b0, o_valid}, 32'd1);
    check("lat_result", {16'b0, o_result}, 32'h4040);
    check("lat_flags", {30'b0, o_flag_nan, o_flag_inf}, 32'd0);
    wait_empty();

    // Special results.
    send(1'b1, 8'h12, 8'h34, 1'b1, 2'b11, 16'h7FC0, 1'b1, 1'b0);
    send(1'b0, 8'h56, 8'h78, 1'b0, 2'b11, 16'hFFC0, 1'b1, 1'b0);
    send(1'b0, 8'h9A, 8'hBC, 1'b0, 2'b10, 16'hFF80, 1'b0, 1'b1);
    wait_empty();
    check("spec_cnt_nan", {30'b0, o_cnt_nan}, 32'd2);
    check("spec_cnt_inf", {30'b0, o_cnt_inf}, 32'd1);

    // Overflow Inf and flush-to-zero.
    send(1'b1, 8'hFF, 8'h80, 1'b0, 2'b00, 16'hFF80, 1'b0, 1'b1);
    check("ovf_flag_inf", {31'b0, o_flag_inf}, 32'd1);
    send(1'b1, 8'h05, 8'h3F, 1'b0, 2'b00, 16'h8000, 1'b0, 1'b0);
    wait_empty();
    check("ovf_cnt_inf", {30'b0, o_cnt_inf}, 32'd2);

    // Backpressure: 8 distinct beats with i_ready cycling 1,0,0,1.
    sent_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] ex;
          ex = 8'h10 + 8'(i);
          send(i[0], ex, 8'h80 | 8'(i), 1'b0, 2'b00,
               {i[0], ex, 7'(i)}, 1'b0, 1'b0);
        end
        sent_done = 1;
      end
      begin
        int p;
        p = 0;
        while (!(sent_done && sb.size() == 0 && occ == 0) && p < 200) begin
          i_ready = pat[p % 4];
          @(posedge i_clk); #1;
          p++;
        end
        if (p >= 200) fail_timeout("bp_timeout");
      end
    join
    i_ready = 1'b1;
    wait_empty();

    // Counter saturation at 2 bits.
    i_clr_cnt = 1'b1;
    @(posedge i_clk); #1;
    i_clr_cnt = 1'b0;
    check("clr_cnts", {28'b0, o_cnt_nan, o_cnt_inf}, 32'd0);
    for (int i = 0; i < 5; i++)
      send(1'b0, 8'h00, 8'h00, 1'b1, 2'b11, 16'h7FC0, 1'b1, 1'b0);
    wait_empty();
    check("sat_cnt_nan", {30'b0, o_cnt_nan}, 32'd3);

    // Clear coinciding with a NaN drain.
    send(1'b0, 8'h00, 8'h00, 1'b0, 2'b11, 16'hFFC0, 1'b1, 1'b0);
    i_clr_cnt = 1'b1;
    @(posedge i_clk); #1;
    i_clr_cnt = 1'b0;
    check("clr_drain_cnt_nan", {30'b0, o_cnt_nan}, 32'd0);
    wait_empty();

    // Reset while FULL.
    send(1'b0, 8'h00, 8'h00, 1'b1, 2'b10, 16'h7F80, 1'b0, 1'b1);
    wait_empty();
    check("pre_rst_cnt_inf", {30'b0, o_cnt_inf}, 32'd1);
    i_ready = 1'b0;
    send(1'b0, 8'h3F, 8'h80, 1'b0, 2'b00, 16'h1F80, 1'b0, 1'b0);
    send(1'b1, 8'h40, 8'h81, 1'b0, 2'b00, 16'hA001, 1'b0, 1'b0);
    check("full_ready", {31'b0, o_ready}, 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    check("mid_rst_cnts", {28'b0, o_cnt_nan, o_cnt_inf}, 32'd0);
    i_ready = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    check("no_stale_beat", {31'b0, o_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bfp16_result_pack.md
# bfp16_result_pack

Output stage of the BFP16 adder pipeline. It takes the normal-path sign/exponent/mantissa plus the special-case select codes produced by the operand classifier and packs them into the final 16-bit BFP16 word. Both the upstream and downstream sides use valid/ready handshakes, and a 2-entry skid buffer sits between them. The block also keeps saturating counters of NaN and Inf results for debug readout.

## Interface
- CNT_W, 16, width of the NaN/Inf event counters
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream result valid
- o_ready  out  1  block can accept the upstream beat
- i_sign  in  1  normal-path sign
- i_exp  in  8  normal-path biased exponent
- i_man  in  8  normal-path mantissa; [7] is the hidden bit, [6:0] is the fraction
- i_sel_exp  in  1  special-result sign select: 1 gives sign 0, 0 gives sign 1
- i_sel_man  in  2  result select: 0x normal, 10 Inf, 11 NaN
- o_valid  out  1  packed result valid
- i_ready  in  1  downstream accepts the result
- o_result  out  16  packed BFP16 as {sign, exp[7:0], frac[6:0]}
- o_flag_nan  out  1  current o_result is NaN
- o_flag_inf  out  1  current o_result is Inf (special or overflow)
- i_clr_cnt  in  1  synchronous clear of both counters
- o_cnt_nan  out  CNT_W  count of NaN results delivered
- o_cnt_inf  out  CNT_W  count of Inf results delivered

## Operation
- Pack rules. Priority is top-down; the pack step is combinational on input capture.
  - i_sel_man=11 gives {~i_sel_exp, 8'hFF, 7'h40}, the canonical quiet NaN. The normal-path inputs are ignored.
  - i_sel_man=10 gives {~i_sel_exp, 8'hFF, 7'h00}.
  - i_sel_man=0x with i_exp=8'hFF gives overflow Inf {i_sign, 8'hFF, 7'h00}. This also sets flag_inf.
  - i_sel_man=0x with i_man[7]=0 gives signed zero {i_sign, 15'h0}. This is flush-to-zero: subnormals are not produced.
  - Otherwise the result is {i_sign, i_exp, i_man[6:0]}.
- Each buffer entry holds the packed result plus its nan and inf flags (18 bits).
- Skid buffer states:
  - EMPTY: o_valid=0, o_ready=1. An accept moves the buffer to ONE.
  - ONE: o_valid=1, o_ready=1.
    - Accept and drain in the same cycle: stay in ONE; the output is replaced by the new beat.
    - Accept only: go to FULL.
    - Drain only: go to EMPTY.
  - FULL: o_valid=1, o_ready=0. A drain moves the skid entry to the output and the buffer goes to ONE.
- Ordering is strictly FIFO. A beat is never dropped or duplicated.
- Handshake rules:
  - Accept means i_valid & o_ready. Drain means o_valid & i_ready.
  - o_ready is a registered signal and does not depend combinationally on i_ready.
  - o_result and the flags are stable while o_valid=1 and i_ready=0.
- Counters:
  - A counter increments on a drain of a beat whose corresponding flag is set.
  - Counters saturate at all-ones.
  - i_clr_cnt has priority over an increment in the same cycle and zeroes the counter.

## Timing
- Reset (i_rst=1 at an edge):
  - State goes to EMPTY.
  - o_valid=0, o_ready=1, o_result=16'h0000.
  - o_flag_nan=0, o_flag_inf=0, o_cnt_nan=0, o_cnt_inf=0.
  - Reset mid-stream discards any buffered beats.
  - Inputs are ignored during the reset cycle.
- Latency:
  - A beat accepted at edge N appears on the outputs with o_valid=1 after edge N, so it is visible in cycle N+1.
  - Throughput is 1 beat per cycle while i_ready=1.
- Stall:
  - After i_ready falls, one more beat is absorbed into the skid entry.
  - o_ready falls after the edge at which the buffer becomes FULL.
- In FULL, i_valid is ignored; upstream must hold the beat.
- Counters update at the same edge as the drain, so they are visible the cycle after the handshake.
- Simultaneous events:
  - Accept and drain in ONE: the count update uses the outgoing beat's flags.
  - i_clr_cnt together with a NaN drain: the counter reads 0 next cycle.

## Test plan
- Reset then a single normal beat (sign=0, exp=8'h80, man=8'hC0, sel_man=00) with i_ready=1 -> o_result=16'h4040 one cycle later, flags 0, counters 0.
- Special beats with sel_man=11/sel_exp=1, then sel_man=11/sel_exp=0, then sel_man=10/sel_exp=0 -> results 16'h7FC0, 16'hFFC0, 16'hFF80; o_cnt_nan=2, o_cnt_inf=1 after all drains.
- Overflow and FTZ: (sign=1, exp=FF, sel_man=00) gives 16'hFF80 with flag_inf=1; (sign=1, exp=05, man=8'h3F, sel_man=00) gives 16'h8000.
- Backpressure: stream 8 distinct beats with i_valid=1 and i_ready toggling 1,0,0,1,… -> o_ready low only while FULL, all 8 results delivered in order, o_result stable while stalled.
- Counter saturation with CNT_W=2: 5 NaN drains -> o_cnt_nan=3. i_clr_cnt asserted alongside a NaN drain -> o_cnt_nan=0.
- Reset asserted while FULL -> next cycle o_valid=0, o_ready=1, counters 0, and no stale beat emerges afterwards.
